// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a bank of multiplexed seven-segment digits sharing one decoder.
// Display values are double-buffered and only become active on frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] disp_val,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic [4:0]              hex_sel,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } load_state_t;

    load_state_t                    state;
    logic [DIV_W-1:0]               presc;
    logic [IW-1:0]                  idx;
    logic                           tick;
    logic                           wrap;

    logic [NUM_DIGITS-1:0][4:0]     active_val;
    logic [NUM_DIGITS-1:0]          active_blank;
    logic [NUM_DIGITS-1:0][4:0]     pend_val;
    logic [NUM_DIGITS-1:0]          pend_blank;

    logic [NUM_DIGITS-1:0]          lz;
    logic [NUM_DIGITS-1:0]          eff_blank;
    logic [NUM_DIGITS-1:0]          sel_oh;
    logic                           nz_above;

    assign tick = (presc == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Scan from the most significant digit down: a digit is a leading zero
    // only while it and everything above it are zero (dashes count as nonzero).
    always_comb begin
        nz_above = 1'b0;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_above = nz_above | (active_val[i] != 5'd0);
            if (i > 0) lz[i] = lz_blank & ~nz_above;
        end
    end

    assign eff_blank = active_blank | lz;

    always_comb begin
        sel_oh      = '0;
        sel_oh[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_sel <= '0;
            dig_en  <= '0;
        end else begin
            hex_sel <= active_val[idx];
            dig_en  <= sel_oh & ~eff_blank;
        end
    end

    // A request landing on the wrap edge goes straight to the active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            active_val   <= {NUM_DIGITS{5'h10}};
            active_blank <= '0;
            pend_val     <= '0;
            pend_blank   <= '0;
            load_ack     <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load_req && wrap) begin
                active_val   <= disp_val;
                active_blank <= blank_mask;
                load_ack     <= 1'b1;
                state        <= IDLE;
            end else if (load_req) begin
                pend_val   <= disp_val;
                pend_blank <= blank_mask;
                state      <= PENDING;
            end else if (state == PENDING && wrap) begin
                active_val   <= pend_val;
                active_blank <= pend_blank;
                load_ack     <= 1'b1;
                state        <= IDLE;
            end
        end
    end

endmodule
